// File: rtl/alu_sequencer.sv
// Execute-stage sequencer for the 4-bit processor: drives the ALU, holds acc/C/Z, resolves jumps.
// Optional macro ALU_SEQ_ILLEGAL_TRAP_EN: opcodes 0xB-0xF enter a sticky TRAP state instead of acting as NOP.
module alu_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       instr_valid,
  input  logic [7:0] instr,
  output logic       instr_ready,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_sel,
  input  logic [3:0] alu_y,
  input  logic       alu_c,
  input  logic       alu_zero,
  output logic [3:0] acc,
  output logic       flag_c,
  output logic       flag_z,
  output logic       pc_load,
  output logic [3:0] pc_target,
  output logic       out_valid,
  output logic [3:0] out_data,
  output logic       trap
);

  localparam int unsigned DW   = 4;
  localparam int unsigned OPW  = 4;
  localparam int unsigned SELW = 3;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_WB   = 2'd2;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
  localparam logic [1:0] S_TRAP = 2'd3;
`endif

  localparam logic [OPW-1:0] OP_LIT  = 4'h1;
  localparam logic [OPW-1:0] OP_ADD  = 4'h2;
  localparam logic [OPW-1:0] OP_SUB  = 4'h3;
  localparam logic [OPW-1:0] OP_NAND = 4'h4;
  localparam logic [OPW-1:0] OP_CMP  = 4'h5;
  localparam logic [OPW-1:0] OP_JC   = 4'h6;
  localparam logic [OPW-1:0] OP_JZ   = 4'h7;
  localparam logic [OPW-1:0] OP_JNZ  = 4'h8;
  localparam logic [OPW-1:0] OP_JMP  = 4'h9;
  localparam logic [OPW-1:0] OP_OUT  = 4'hA;

  localparam logic [SELW-1:0] SEL_A    = 3'b000;
  localparam logic [SELW-1:0] SEL_SUB  = 3'b001;
  localparam logic [SELW-1:0] SEL_B    = 3'b010;
  localparam logic [SELW-1:0] SEL_ADD  = 3'b011;
  localparam logic [SELW-1:0] SEL_NAND = 3'b100;

  logic [1:0]      state, state_n;
  logic [OPW-1:0]  op_q, op_n;
  logic [DW-1:0]   imm_n;
  logic [DW-1:0]   acc_n, alu_b_n, out_data_n;
  logic [SELW-1:0] alu_sel_n;
  logic            flag_c_n, flag_z_n, pc_load_n, out_valid_n, ready_n;
  logic            trap_q, trap_n;

  assign alu_a = acc;

`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
  assign trap = trap_q;
`else
  assign trap = 1'b0;
`endif

  // Next-state and next-output decode; register writes happen on the edge leaving EXEC.
  always_comb begin
    state_n     = state;
    op_n        = op_q;
    imm_n       = pc_target;
    acc_n       = acc;
    flag_c_n    = flag_c;
    flag_z_n    = flag_z;
    alu_b_n     = DW'(0);
    alu_sel_n   = SEL_A;
    pc_load_n   = 1'b0;
    out_valid_n = 1'b0;
    out_data_n  = out_data;
    trap_n      = trap_q;
    case (state)
      S_IDLE: begin
        if (instr_valid && instr_ready) begin
          op_n    = instr[7:4];
          imm_n   = instr[3:0];
          alu_b_n = instr[3:0];
          state_n = S_EXEC;
          case (instr[7:4])
            OP_LIT:         alu_sel_n = SEL_B;
            OP_ADD:         alu_sel_n = SEL_ADD;
            OP_SUB, OP_CMP: alu_sel_n = SEL_SUB;
            OP_NAND:        alu_sel_n = SEL_NAND;
            OP_JC:          pc_load_n = flag_c;
            OP_JZ:          pc_load_n = flag_z;
            OP_JNZ:         pc_load_n = !flag_z;
            OP_JMP:         pc_load_n = 1'b1;
            OP_OUT: begin
              out_valid_n = 1'b1;
              out_data_n  = acc;
            end
            default: ;
          endcase
        end
      end
      S_EXEC: begin
        state_n = S_IDLE;
        case (op_q)
          OP_LIT, OP_NAND: begin
            acc_n    = alu_y;
            flag_z_n = alu_zero;
            state_n  = S_WB;
          end
          OP_ADD, OP_SUB: begin
            acc_n    = alu_y;
            flag_c_n = alu_c;
            flag_z_n = alu_zero;
            state_n  = S_WB;
          end
          OP_CMP: begin
            flag_c_n = alu_c;
            flag_z_n = alu_zero;
            state_n  = S_WB;
          end
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
          default: begin
            if (op_q > OP_OUT) begin
              state_n = S_TRAP;
              trap_n  = 1'b1;
            end
          end
`else
          default: ;
`endif
        endcase
      end
      S_WB: state_n = S_IDLE;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
      S_TRAP: state_n = S_TRAP;
`endif
      default: state_n = S_IDLE;
    endcase
    ready_n = (state_n == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      op_q        <= OPW'(0);
      pc_target   <= DW'(0);
      acc         <= DW'(0);
      flag_c      <= 1'b0;
      flag_z      <= 1'b0;
      alu_b       <= DW'(0);
      alu_sel     <= SEL_A;
      pc_load     <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= DW'(0);
      instr_ready <= 1'b1;
      trap_q      <= 1'b0;
    end else begin
      state       <= state_n;
      op_q        <= op_n;
      pc_target   <= imm_n;
      acc         <= acc_n;
      flag_c      <= flag_c_n;
      flag_z      <= flag_z_n;
      alu_b       <= alu_b_n;
      alu_sel     <= alu_sel_n;
      pc_load     <= pc_load_n;
      out_valid   <= out_valid_n;
      out_data    <= out_data_n;
      instr_ready <= ready_n;
      trap_q      <= trap_n;
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer with a behavioural ALU; expectations come from a reference model.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       instr_valid;
  logic [7:0] instr;
  logic       instr_ready;
  logic [3:0] alu_a, alu_b, alu_y, acc, pc_target, out_data;
  logic [2:0] alu_sel;
  logic       alu_c, alu_zero, flag_c, flag_z, pc_load, out_valid, trap;
  logic       force_c0 = 1'b0;
  logic [4:0] r5;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [3:0] acc;
    logic       c;
    logic       z;
    logic [2:0] sel;
    logic [3:0] b;
    int         pcl;
    int         ov;
    logic [3:0] tgt;
    logic [3:0] od;
    int         lowc;
    logic       trap;
  } exp_t;

  exp_t sb[$];

  logic [3:0] m_acc, m_od;
  logic       m_c, m_z, m_trap;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_y(alu_y), .alu_c(alu_c), .alu_zero(alu_zero), .acc(acc),
    .flag_c(flag_c), .flag_z(flag_z), .pc_load(pc_load), .pc_target(pc_target),
    .out_valid(out_valid), .out_data(out_data), .trap(trap)
  );

  // Behavioural combinational ALU; force_c0 pins carry low.
  always_comb begin
    case (alu_sel)
      3'b001:  r5 = {1'b0, alu_a} - {1'b0, alu_b};
      3'b010:  r5 = {1'b0, alu_b};
      3'b011:  r5 = {1'b0, alu_a} + {1'b0, alu_b};
      3'b100:  r5 = {1'b0, ~(alu_a & alu_b)};
      default: r5 = {1'b0, alu_a};
    endcase
    alu_y    = r5[3:0];
    alu_zero = (r5[3:0] == 4'h0);
    alu_c    = force_c0 ? 1'b0 : r5[4];
  end

  task automatic check(input string tag, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_acc = 4'h0; m_c = 1'b0; m_z = 1'b0; m_od = 4'h0; m_trap = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    instr_valid = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    check("rst_acc", int'(acc), 0);
    check("rst_c", int'(flag_c), 0);
    check("rst_z", int'(flag_z), 0);
    check("rst_ready", int'(instr_ready), 1);
    check("rst_pcl", int'(pc_load), 0);
    check("rst_ov", int'(out_valid), 0);
    check("rst_trap", int'(trap), 0);
    check("rst_sel", int'(alu_sel), 0);
    check("rst_b", int'(alu_b), 0);
    check("rst_tgt", int'(pc_target), 0);
    check("rst_od", int'(out_data), 0);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Reference model: compute the expectation for one instruction and push it.
  task automatic push_expect(input logic [3:0] op, input logic [3:0] imm);
    exp_t e;
    logic [4:0] s5;
    logic [3:0] d;
    e.sel = 3'b000; e.pcl = 0; e.ov = 0; e.lowc = 1;
    case (op)
      4'h1: begin e.sel = 3'b010; m_acc = imm; m_z = (imm == 4'h0); e.lowc = 2; end
      4'h2: begin
        e.sel = 3'b011; s5 = {1'b0, m_acc} + {1'b0, imm};
        m_acc = s5[3:0]; m_c = s5[4]; m_z = (s5[3:0] == 4'h0); e.lowc = 2;
      end
      4'h3, 4'h5: begin
        e.sel = 3'b001; d = m_acc - imm;
        m_c = (m_acc < imm); m_z = (d == 4'h0); e.lowc = 2;
        if (op == 4'h3) m_acc = d;
      end
      4'h4: begin e.sel = 3'b100; m_acc = ~(m_acc & imm); m_z = (m_acc == 4'h0); e.lowc = 2; end
      4'h6: e.pcl = m_c ? 1 : 0;
      4'h7: e.pcl = m_z ? 1 : 0;
      4'h8: e.pcl = m_z ? 0 : 1;
      4'h9: e.pcl = 1;
      4'hA: begin e.ov = 1; m_od = m_acc; end
      default: begin
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
        if (op > 4'hA) begin e.lowc = 8; m_trap = 1'b1; end
`endif
      end
    endcase
    e.acc = m_acc; e.c = m_c; e.z = m_z; e.b = imm; e.tgt = imm;
    e.od = m_od; e.trap = m_trap;
    sb.push_back(e);
  endtask

  task automatic run_instr(input logic [3:0] op, input logic [3:0] imm);
    exp_t e;
    int n, pcl, ov, low;
    logic [2:0] sel_seen;
    logic [3:0] b_seen;
    push_expect(op, imm);
    n = 0;
    while (!instr_ready && n < 20) begin @(negedge clk); n++; end
    if (!instr_ready) check("ready_timeout", 0, 1);
    instr_valid = 1'b1;
    instr = {op, imm};
    @(posedge clk);
    #1 instr_valid = 1'b0;
    instr = 8'($urandom);
    pcl = 0; ov = 0; low = 0; sel_seen = 3'b000; b_seen = 4'h0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) begin sel_seen = alu_sel; b_seen = alu_b; end
      if (pc_load) pcl++;
      if (out_valid) ov++;
      if (instr_ready) break;
      low++;
    end
    e = sb.pop_front();
    check($sformatf("op%h_acc", op), int'(acc), int'(e.acc));
    check($sformatf("op%h_c", op), int'(flag_c), int'(e.c));
    check($sformatf("op%h_z", op), int'(flag_z), int'(e.z));
    check($sformatf("op%h_sel", op), int'(sel_seen), int'(e.sel));
    check($sformatf("op%h_b", op), int'(b_seen), int'(e.b));
    check($sformatf("op%h_pcl", op), pcl, e.pcl);
    check($sformatf("op%h_ov", op), ov, e.ov);
    check($sformatf("op%h_tgt", op), int'(pc_target), int'(e.tgt));
    check($sformatf("op%h_od", op), int'(out_data), int'(e.od));
    check($sformatf("op%h_busy", op), low, e.lowc);
    check($sformatf("op%h_trap", op), int'(trap), int'(e.trap));
  endtask

  initial begin
    rst_n = 1'b0;
    instr_valid = 1'b0;
    instr = 8'h00;
    model_reset();
    @(negedge clk);
    do_reset();

    run_instr(4'h1, 4'h5);
    run_instr(4'h2, 4'hC);
    run_instr(4'h1, 4'h3);
    run_instr(4'h3, 4'h3);
    run_instr(4'h5, 4'h4);

    run_instr(4'h1, 4'h9);
    run_instr(4'h2, 4'h9);
    run_instr(4'h1, 4'hF);
    force_c0 = 1'b1;
    run_instr(4'h4, 4'hF);
    force_c0 = 1'b0;

    run_instr(4'h7, 4'h9);
    run_instr(4'h8, 4'h9);
    run_instr(4'h9, 4'h2);
    run_instr(4'h6, 4'h5);
    run_instr(4'h1, 4'h7);
    run_instr(4'hA, 4'h0);

    // Reset landing in the WB cycle of ADD 0xF on acc=1.
    run_instr(4'h1, 4'h1);
    instr_valid = 1'b1;
    instr = 8'h2F;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    model_reset();
    check("wbrst_acc", int'(acc), 0);
    check("wbrst_c", int'(flag_c), 0);
    check("wbrst_z", int'(flag_z), 0);
    check("wbrst_ready", int'(instr_ready), 1);
    check("wbrst_tgt", int'(pc_target), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 24; i++)
      run_instr(4'($urandom_range(0, 10)), 4'($urandom_range(0, 15)));

    run_instr(4'hC, 4'h3);
    run_instr(4'h1, 4'h6);

    do_reset();
    run_instr(4'h1, 4'h2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

- Execute-stage control block of the 4-bit processor. It accepts one 8-bit instruction at a time (opcode[7:4], immediate[3:0]) and drives `alu_a`, `alu_b` and `alu_sel` toward the combinational ALU.
- It consumes the ALU's `alu_y`, `alu_c` and `alu_zero` results and holds the architectural accumulator and C/Z flag registers.
- It resolves conditional jumps for the program counter and sits between instruction fetch and the ALU.

## Interface
Parameters: none.
- `clk`  in  1  single clock; all state updates on rising edge
- `rst_n`  in  1  synchronous active-low reset
- `instr_valid`  in  1  instruction present on `instr`
- `instr`  in  8  [7:4] opcode, [3:0] immediate
- `instr_ready`  out  1  block can accept an instruction this cycle
- `alu_a`  out  4  ALU operand A (accumulator)
- `alu_b`  out  4  ALU operand B (latched immediate)
- `alu_sel`  out  3  ALU selector: 000 pass A, 001 A-B, 010 pass B, 011 A+B, 100 NAND
- `alu_y`  in  4  ALU result
- `alu_c`  in  1  ALU carry/borrow (bit 4 of 5-bit result)
- `alu_zero`  in  1  ALU result-is-zero
- `acc`  out  4  accumulator
- `flag_c`, `flag_z`  out  1 each  registered flags
- `pc_load`  out  1  one-cycle pulse: PC takes `pc_target`
- `pc_target`  out  4  jump address (immediate)
- `out_valid`  out  1  one-cycle pulse; `out_data` valid
- `out_data`  out  4  output-port value
- `trap`  out  1  sticky illegal-opcode indicator (only with macro, else tied 0)

## Operation
- FSM states: IDLE, EXEC, WB, plus TRAP when the macro is defined.
- **IDLE:** `instr_ready`=1. When `instr_valid`&`instr_ready`, latch opcode and immediate, go to EXEC.
- **EXEC:** `alu_sel`/`alu_b` driven from the latched instruction; `alu_a`=`acc` always.
  - ALU-class opcodes go to WB.
  - Jump/NOP/OUT return to IDLE.
- **WB:** no ALU drive (`alu_sel`=000, `alu_b`=0); returns to IDLE.
- Outside EXEC: `alu_sel`=000 and `alu_b`=0.
- Opcodes:
  - 0x0 NOP: no effect.
  - 0x1 LIT: sel 010; `acc`←`alu_y`; Z←`alu_zero`; C held.
  - 0x2 ADD: sel 011; `acc`←`alu_y`; C←`alu_c`; Z←`alu_zero`.
  - 0x3 SUB: sel 001; same updates as ADD. C=1 means borrow (A<B).
  - 0x4 NAND: sel 100; `acc`←`alu_y`; Z←`alu_zero`; C held. The ALU's C output is not meaningful for non-arithmetic selects and is never sampled for them.
  - 0x5 CMP: sel 001; C, Z updated; `acc` unchanged.
  - 0x6 JC / 0x7 JZ / 0x8 JNZ: `pc_load`=1 in EXEC if the condition holds on the current flags.
  - 0x9 JMP: `pc_load`=1 unconditionally.
  - 0xA OUT: sel 000; `out_valid`=1 in EXEC with `out_data`=`alu_y` (=`acc`).
  - 0xB–0xF: illegal (see Configuration).
- `acc` and flag registers are written on the clock edge that leaves EXEC. WB exists so fetch never overlaps a register update.
- `pc_target` = latched immediate, held until the next accept.

## Timing
- Reset (`rst_n` low at a rising edge), from any state, including mid-EXEC/WB:
  - state IDLE.
  - `acc`, `flag_c`, `flag_z`, `alu_b`, `alu_sel`, `pc_target`, `out_data` = 0.
  - `pc_load`, `out_valid`, `trap` = 0.
  - Any pending register write is discarded.
- Throughput:
  - ALU-class: 3 cycles (IDLE→EXEC→WB).
  - Jump/OUT/NOP: 2 cycles.
- `instr_ready` is low in EXEC, WB and TRAP. `instr` is ignored when `instr_ready`=0.
- `pc_load` and `out_valid` are high exactly one cycle (the EXEC cycle), registered from the accept edge.
- Conditional jumps see flags written by the immediately preceding instruction, because that instruction's WB completes before the next accept.
- Arithmetic is modulo 16. Flags come only from the ALU, never recomputed locally.

## Configuration
- `ALU_SEQ_ILLEGAL_TRAP_EN` defined:
  - Opcodes 0xB–0xF go IDLE→TRAP. TRAP is entered on the edge after EXEC; EXEC performs no action.
  - In TRAP: `trap`=1 and `instr_ready`=0 until reset.
  - `acc`/flags frozen.
- Not defined: 0xB–0xF execute as NOP (2 cycles); `trap` tied 0; TRAP state absent.

## Test plan
- Reset, then LIT 0x5, ADD 0xC → `acc`=0x1, `flag_c`=1, `flag_z`=0; ADD occupies 3 cycles, with `instr_ready` low for 2.
- LIT 0x3, SUB 0x3 → `acc`=0, Z=1, C=0. Then CMP 0x4 → C=1 (borrow), Z=0, `acc` still 0.
- Carry retention: ADD producing C=1, then NAND 0xF with `acc`=0xF → `acc`=0x0, Z=1, C stays 1. Drive `alu_c`=0 by force during NAND; C must still stay 1.
- Jumps: with Z=1, JZ 0x9 → `pc_load` pulse 1 cycle, `pc_target`=0x9. JNZ 0x9 → no pulse. JMP 0x2 → pulse. OUT with `acc`=0x7 → `out_valid` 1 cycle, `out_data`=0x7.
- `rst_n` low during WB of ADD 0xF on `acc`=0x1 → `acc`=0, C=0, Z=0, state IDLE, `instr_ready`=1 next cycle.
- Opcode 0xC:
  - With macro: `trap`=1 and `instr_ready`=0 permanently until reset.
  - Without macro: NOP, `instr_ready` back to 1 after 2 cycles.
